// File: rtl/screen_pkg.sv
// Shared screen constants: palette indices, grid size and renderer FSM states.
package screen;
  localparam int GRID_N = 9;

  localparam logic [3:0] COL_GRID  = 4'd7;
  localparam logic [3:0] COL_DIGIT = 4'd15;
  localparam logic [3:0] COL_BG    = 4'd1;

  typedef enum logic [1:0] {R_IDLE, R_DRAW, R_FIN} rend_state;
endpackage

// File: rtl/digit_glyph_rom.sv
// 8x8 digit font, one row per lookup; bit 7 is the leftmost pixel.
module digit_glyph_rom (
  input  logic [3:0] digit,
  input  logic [2:0] gy,
  output logic [7:0] row_bits
);
  logic [63:0] glyph;

  always_comb begin
    glyph = '0;
    case (digit)
      4'd1: glyph = 64'h1838181818187E00;
      4'd2: glyph = 64'h3C66060C30607E00;
      4'd3: glyph = 64'h3C66061C06663C00;
      4'd4: glyph = 64'h0C1C3C6C7E0C0C00;
      4'd5: glyph = 64'h7E607C0606663C00;
      4'd6: glyph = 64'h3C607C6666663C00;
      4'd7: glyph = 64'h7E060C1830303000;
      4'd8: glyph = 64'h3C66663C66663C00;
      4'd9: glyph = 64'h3C66663E060C3800;
      default: glyph = '0;
    endcase
    // row 0 sits in the top byte
    row_bits = glyph[{3'd7 - gy, 3'b000} +: 8];
  end
endmodule

// File: rtl/cell_renderer.sv
// Rasterises one board cell (border, background, digit glyph) into framebuffer writes.
module cell_renderer
  import screen::*;
#(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int X0      = 16,
  parameter int Y0      = 16,
  parameter int CELL_PX = 16,
  parameter int COL_W   = 4,
  localparam int AW     = $clog2(H_RES * V_RES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_cell,
  input  logic [3:0]       cell_row,
  input  logic [3:0]       cell_col,
  input  logic [3:0]       cell_data,
  output logic             fb_we,
  output logic [AW-1:0]    fb_addr,
  output logic [COL_W-1:0] fb_wdata,
  input  logic             fb_ready,
  output logic             busy,
  output logic             done
);
  localparam int PW  = $clog2(CELL_PX);
  localparam int OFF = (CELL_PX - 8) / 2;
  localparam logic [PW-1:0] LAST = PW'(CELL_PX - 1);

  rend_state state, state_nxt;
  logic [PW-1:0] px, py;
  logic [3:0]    row_q, col_q, data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= R_IDLE;
      px     <= '0;
      py     <= '0;
      row_q  <= '0;
      col_q  <= '0;
      data_q <= '0;
      busy   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        R_IDLE: if (start_cell) begin
          row_q  <= cell_row;
          col_q  <= cell_col;
          data_q <= cell_data;
          px     <= '0;
          py     <= '0;
          busy   <= 1'b1;
        end
        R_DRAW: if (fb_ready) begin
          px <= (px == LAST) ? '0 : px + 1'b1;
          if (px == LAST) py <= py + 1'b1;
        end
        R_FIN:   busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    fb_we     = 1'b0;
    done      = 1'b0;
    case (state)
      R_IDLE: if (start_cell)
        state_nxt = (cell_row >= 4'(GRID_N) || cell_col >= 4'(GRID_N)) ? R_FIN : R_DRAW;
      R_DRAW: begin
        fb_we = 1'b1;
        if (fb_ready && px == LAST && py == LAST) state_nxt = R_FIN;
      end
      R_FIN: begin
        done      = 1'b1;
        state_nxt = R_IDLE;
      end
      default: state_nxt = R_IDLE;
    endcase
  end

  // Address and colour derive purely from registered state, so they hold while stalled.
  logic [AW-1:0] x, y;
  logic [7:0]    row_bits;
  logic [2:0]    gx;
  logic          in_win, is_digit;
  logic [COL_W-1:0] colour;

  assign x = AW'(X0) + AW'(col_q) * AW'(CELL_PX) + AW'(px);
  assign y = AW'(Y0) + AW'(row_q) * AW'(CELL_PX) + AW'(py);

  assign in_win   = int'(px) >= OFF && int'(px) < OFF + 8 &&
                    int'(py) >= OFF && int'(py) < OFF + 8;
  assign is_digit = data_q >= 4'd1 && data_q <= 4'd9;
  assign gx       = 3'(px - PW'(OFF));

  digit_glyph_rom u_rom (
    .digit    (data_q),
    .gy       (3'(py - PW'(OFF))),
    .row_bits (row_bits)
  );

  always_comb begin
    colour = COL_W'(COL_BG);
    if (px == '0 || py == '0)                              colour = COL_W'(COL_GRID);
    else if (in_win && is_digit && row_bits[3'd7 - gx])    colour = COL_W'(COL_DIGIT);
  end

  assign fb_addr  = fb_we ? y * AW'(H_RES) + x : '0;
  assign fb_wdata = fb_we ? colour : '0;
endmodule

// File: tb/tb_cell_renderer.sv
// Scoreboard bench: driver queues expected pixels, monitor pops on every accepted write.
module tb_cell_renderer;
  import screen::*;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_cell = 1'b0;
  logic [3:0]    cell_row = '0, cell_col = '0, cell_data = '0;
  logic          fb_we, busy, done;
  logic          fb_ready = 1'b1;
  logic [AW-1:0] fb_addr;
  logic [3:0]    fb_wdata;

  cell_renderer dut (
    .clk(clk), .rst(rst), .start_cell(start_cell),
    .cell_row(cell_row), .cell_col(cell_col), .cell_data(cell_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_ready(fb_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1 fb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  typedef struct { int addr; int col; } pix_t;
  pix_t exp_q[$];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] font_row(int d, int r);
    logic [63:0] g;
    case (d)
      1: g = 64'h1838181818187E00;
      2: g = 64'h3C66060C30607E00;
      3: g = 64'h3C66061C06663C00;
      4: g = 64'h0C1C3C6C7E0C0C00;
      5: g = 64'h7E607C0606663C00;
      6: g = 64'h3C607C6666663C00;
      7: g = 64'h7E060C1830303000;
      8: g = 64'h3C66663C66663C00;
      9: g = 64'h3C66663E060C3800;
      default: g = '0;
    endcase
    return g[63 - 8*r -: 8];
  endfunction

  // Reference raster: row-major over the cell, pixel colour from the priority rules.
  function automatic void push_cell(int r, int c, int d);
    pix_t p;
    logic [7:0] fr;
    if (r > 8 || c > 8) return;
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++) begin
        p.addr = (16 + r*16 + yy) * 320 + (16 + c*16 + xx);
        p.col  = COL_BG;
        if (xx == 0 || yy == 0) p.col = COL_GRID;
        else if (d >= 1 && d <= 9 && xx >= 4 && xx < 12 && yy >= 4 && yy < 12) begin
          fr = font_row(d, yy - 4);
          if (fr[7 - (xx - 4)]) p.col = COL_DIGIT;
        end
        exp_q.push_back(p);
      end
  endfunction

  int wr_count = 0, done_count = 0, busy_count = 0;
  logic          stall_prev = 1'b0;
  logic [AW-1:0] held_addr;
  logic [3:0]    held_data;

  always @(negedge clk) begin
    pix_t e;
    if (rst) stall_prev = 1'b0;
    else begin
      if (busy) busy_count++;
      if (done) done_count++;
      if (stall_prev) begin
        chk("we_held_while_stalled", int'(fb_we), 1);
        if (fb_we) begin
          chk("addr_held", int'(fb_addr), int'(held_addr));
          chk("data_held", int'(fb_wdata), int'(held_data));
        end
      end
      if (fb_we && fb_ready) begin
        wr_count++;
        if (exp_q.size() == 0) chk("unexpected_write_addr", int'(fb_addr), -1);
        else begin
          e = exp_q.pop_front();
          chk("write_addr", int'(fb_addr), e.addr);
          chk("write_colour", int'(fb_wdata), e.col);
        end
      end
      stall_prev = fb_we && !fb_ready;
      held_addr  = fb_addr;
      held_data  = fb_wdata;
    end
  end

  // lat < 0: fb_ready is random, so latency and busy length are not fixed.
  task automatic run_cell(int r, int c, int d, int lat);
    int w0, d0, b0, n, k;
    bit in_range;
    in_range = (r <= 8 && c <= 8);
    push_cell(r, c, d);
    w0 = wr_count; d0 = done_count; b0 = busy_count;
    @(posedge clk); #1;
    start_cell = 1'b1; cell_row = 4'(r); cell_col = 4'(c); cell_data = 4'(d);
    @(negedge clk);
    chk("idle_before_accept", int'(busy), 0);
    n = cyc;
    @(posedge clk); #1;
    start_cell = 1'b0;
    cell_row = 4'($urandom); cell_col = 4'($urandom); cell_data = 4'($urandom);
    @(negedge clk);
    chk("first_cycle_we", int'(fb_we), int'(in_range));
    k = 0;
    while (!done && k < 5000) begin @(negedge clk); k++; end
    if (k >= 5000) chk("done_timeout", 0, 1);
    else if (lat > 0) chk("done_latency", cyc - n, lat);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("write_count", wr_count - w0, in_range ? 256 : 0);
    chk("done_pulses", done_count - d0, 1);
    if (lat > 0) chk("busy_cycles", busy_count - b0, lat);
    chk("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int w0, d0, k;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("reset_we", int'(fb_we), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_addr", int'(fb_addr), 0);
    end

    run_cell(0, 0, 0, 257);
    run_cell(8, 8, 5, 257);

    rand_ready = 1'b1;
    run_cell(4, 7, 8, -1);
    run_cell($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(1, 9), -1);
    rand_ready = 1'b0;
    repeat (3) run_cell($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 15), 257);

    run_cell(9, 2, 0, 1);
    run_cell(3, 12, 4, 1);
    run_cell(15, 15, 9, 1);

    // Abort a cell in flight with reset, then check a clean restart.
    push_cell(2, 3, 7);
    w0 = wr_count; d0 = done_count;
    @(posedge clk); #1;
    start_cell = 1'b1; cell_row = 4'd2; cell_col = 4'd3; cell_data = 4'd7;
    @(posedge clk); #1 start_cell = 1'b0;
    k = 0;
    while (wr_count - w0 < 100 && k < 2000) begin @(negedge clk); k++; end
    if (k >= 2000) chk("reset_wait_timeout", 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we", int'(fb_we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_we", int'(fb_we), 0);
      chk("post_abort_done", int'(done), 0);
    end
    chk("post_abort_done_pulses", done_count - d0, 0);
    run_cell(0, 0, 3, 257);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
